// File: rtl/spi_slv.sv
`default_nettype none
// ============================================================================
// spi_slv : oversampled SPI mode-0 slave; SPI_SLV_SYNC2_EN selects 2-flop sync.
// Revision: 1.0
// ============================================================================
module spi_slv #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_clk,
  input  logic          spi_ssn,
  input  logic          spi_mosi,
  output logic          spi_miso_o,
  output logic          spi_miso_e,
  output logic          rx_vld,
  output logic [BW-1:0] rx_dat,
  input  logic          tx_vld,
  input  logic [BW-1:0] tx_dat,
  output logic          tx_rdy,
  output logic          tx_unf,
  output logic          busy
);

`ifdef SPI_SLV_SYNC2_EN
  localparam int N = 2;
`else
  localparam int N = 1;
`endif
  localparam int CW = $clog2(BW) + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  sclk_sync_q, sclk_sync_d;
  logic [N-1:0]  ssn_sync_q, ssn_sync_d;
  logic [N-1:0]  mosi_sync_q, mosi_sync_d;
  logic [N-1:0]  flush_q, flush_d;
  logic          sclk_dly_q, sclk_dly_d;
  logic          ssn_dly_q, ssn_dly_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-2:0] rx_sh_q, rx_sh_d;
  logic [BW-1:0] tx_sh_q, tx_sh_d;
  logic [BW-1:0] rx_dat_q, rx_dat_d;
  logic          rx_vld_q, rx_vld_d;
  logic          tx_rdy_q, tx_rdy_d;
  logic          tx_unf_q, tx_unf_d;
  logic          busy_q, busy_d;

  logic          sclk_s, ssn_s, mosi_s;
  logic          sel_fall, sel_rise, sclk_rise, sclk_fall;
  logic [BW-1:0] tx_load;
  logic [CW-1:0] cnt_inc;

  assign sclk_s    = sclk_sync_q[N-1];
  assign ssn_s     = ssn_sync_q[N-1];
  assign mosi_s    = mosi_sync_q[N-1];
  // A select fall only counts once a genuine high ssn has been seen since
  // reset, so a reset inside a frame never joins that frame halfway.
  assign sel_fall  = armed_q & ssn_dly_q & ~ssn_s;
  assign sel_rise  = ~ssn_dly_q & ssn_s;
  assign sclk_rise = ~sclk_dly_q & sclk_s;
  assign sclk_fall = sclk_dly_q & ~sclk_s;
  assign tx_load   = tx_vld ? tx_dat : '0;
  assign cnt_inc   = cnt_q + CW'(1);

  always_comb begin
    sclk_sync_d = N'({sclk_sync_q, spi_clk});
    ssn_sync_d  = N'({ssn_sync_q, spi_ssn});
    mosi_sync_d = N'({mosi_sync_q, spi_mosi});
    flush_d     = N'({flush_q, 1'b1});
    sclk_dly_d  = sclk_s;
    ssn_dly_d   = ssn_s;
    armed_d     = armed_q | (flush_q[N-1] & ssn_s);
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    rx_dat_d    = rx_dat_q;
    rx_vld_d    = 1'b0;
    tx_rdy_d    = 1'b0;
    tx_unf_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_fall) begin
          tx_sh_d  = tx_load;
          tx_rdy_d = 1'b1;
          tx_unf_d = ~tx_vld;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (sel_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          rx_sh_d = '0;
        end else if (sclk_rise) begin
          rx_sh_d = (BW-1)'({rx_sh_q, mosi_s});
          if (cnt_inc == CW'(BW)) begin
            rx_dat_d = {rx_sh_q, mosi_s};
            rx_vld_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (sclk_fall) begin
          // A fall with the counter at zero marks a word boundary.
          if (cnt_q == '0) begin
            tx_sh_d  = tx_load;
            tx_rdy_d = 1'b1;
            tx_unf_d = ~tx_vld;
          end else begin
            tx_sh_d = {tx_sh_q[BW-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      ssn_sync_q  <= '1;
      mosi_sync_q <= '0;
      flush_q     <= '0;
      sclk_dly_q  <= 1'b0;
      ssn_dly_q   <= 1'b1;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      rx_dat_q    <= '0;
      rx_vld_q    <= 1'b0;
      tx_rdy_q    <= 1'b0;
      tx_unf_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ssn_sync_q  <= ssn_sync_d;
      mosi_sync_q <= mosi_sync_d;
      flush_q     <= flush_d;
      sclk_dly_q  <= sclk_dly_d;
      ssn_dly_q   <= ssn_dly_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      rx_dat_q    <= rx_dat_d;
      rx_vld_q    <= rx_vld_d;
      tx_rdy_q    <= tx_rdy_d;
      tx_unf_q    <= tx_unf_d;
      busy_q      <= busy_d;
    end
  end

  assign spi_miso_o = tx_sh_q[BW-1];
  assign spi_miso_e = busy_q;
  assign busy       = busy_q;
  assign rx_vld     = rx_vld_q;
  assign rx_dat     = rx_dat_q;
  assign tx_rdy     = tx_rdy_q;
  assign tx_unf     = tx_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slv.sv
`default_nettype none
// ============================================================================
// tb_spi_slv : SPI master model with event-time scoreboard for spi_slv.
// Revision: 1.0
// ============================================================================
module tb_spi_slv;
  localparam int BW = 8;
`ifdef SPI_SLV_SYNC2_EN
  localparam int N = 2;
`else
  localparam int N = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spi_clk = 1'b0;
  logic          spi_ssn = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          spi_miso_o, spi_miso_e, rx_vld, tx_rdy, tx_unf, busy;
  logic [BW-1:0] rx_dat;
  logic          tx_vld = 1'b1;
  logic [BW-1:0] tx_dat = 8'h00;

  always #5 clk = ~clk;

  spi_slv #(.BW(BW)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_ssn(spi_ssn), .spi_mosi(spi_mosi),
    .spi_miso_o(spi_miso_o), .spi_miso_e(spi_miso_e), .rx_vld(rx_vld), .rx_dat(rx_dat),
    .tx_vld(tx_vld), .tx_dat(tx_dat), .tx_rdy(tx_rdy), .tx_unf(tx_unf), .busy(busy)
  );

  typedef struct {int c; logic [7:0] v;} ev_t;
  ev_t        rxq[$], rdyq[$], selq[$];
  logic [7:0] mexp[$], txq[$], reads[$];
  logic [7:0] fw[4];
  int cyc = 0, n_chk = 0, n_fail = 0;
  int rx_cnt = 0, rdy_cnt = 0, unf_cnt = 0, last_rx_cyc = 0, last_rise_t = 0;
  int reload_req = 0, reload_ack = 0;
  bit   min_ph = 1'b0;
  logic exp_sel = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm, input int act, input int exp);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Scoreboard: every DUT event must land exactly on the cycle the master
  // predicted (sampling edge of the SPI change plus N).
  always @(negedge clk) begin
    if (reload_req != reload_ack) begin
      reload_ack = reload_req;
      tx_dat = txq.pop_front();
    end
    if (selq.size() > 0 && selq[0].c == cyc) begin
      exp_sel = selq[0].v[0];
      void'(selq.pop_front());
    end
    chk("miso_e", spi_miso_e, exp_sel);
    chk("busy", busy, exp_sel);

    if (rx_vld) begin
      rx_cnt++;
      last_rx_cyc = cyc;
      if (rxq.size() == 0) bad("rx_vld_unexpected", cyc, -1);
      else begin
        chk("rx_vld_cycle", cyc, rxq[0].c);
        chk("rx_dat", rx_dat, rxq[0].v);
        void'(rxq.pop_front());
      end
    end else if (rxq.size() > 0 && rxq[0].c <= cyc) begin
      bad("rx_vld_missing", cyc, rxq[0].c);
      void'(rxq.pop_front());
    end

    if (tx_rdy) begin
      rdy_cnt++;
      if (rdyq.size() == 0) bad("tx_rdy_unexpected", cyc, -1);
      else begin
        chk("tx_rdy_cycle", cyc, rdyq[0].c);
        void'(rdyq.pop_front());
      end
      chk("tx_unf", tx_unf, !tx_vld);
      if (tx_unf) unf_cnt++;
      mexp.push_back(tx_vld ? tx_dat : 8'h00);
      if (tx_vld) tx_dat = (txq.size() > 0) ? txq.pop_front() : 8'($urandom);
    end else begin
      chk("tx_unf_without_rdy", tx_unf, 0);
      if (rdyq.size() > 0 && rdyq[0].c <= cyc) begin
        bad("tx_rdy_missing", cyc, rdyq[0].c);
        void'(rdyq.pop_front());
      end
    end
  end

  task automatic wait_ph();
    int p;
    p = min_ph ? N + 2 : N + 2 + int'($urandom_range(0, 2));
    repeat (p) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_miso_o"}, spi_miso_o, 0);
    chk({tag, "_miso_e"}, spi_miso_e, 0);
    chk({tag, "_rx_vld"}, rx_vld, 0);
    chk({tag, "_rx_dat"}, rx_dat, 0);
    chk({tag, "_tx_rdy"}, tx_rdy, 0);
    chk({tag, "_tx_unf"}, tx_unf, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Master: nw words from fw[]; abort_bits>0 ends the frame after that many
  // bits; rst_bit>0 pulses slave reset on that rising edge.
  task automatic frame(input int nw, input int abort_bits, input int rst_bit);
    logic [7:0] rd;
    int  bitn;
    bit  dead;
    bitn = 0;
    dead = 1'b0;
    reads.delete();
    @(negedge clk);
    spi_ssn = 1'b0;
    selq.push_back('{cyc + 1 + N, 8'h01});
    rdyq.push_back('{cyc + 1 + N, 8'h00});
    wait_ph();
    for (int w = 0; w < nw; w++) begin
      rd = 8'h00;
      for (int b = BW - 1; b >= 0; b--) begin
        if (abort_bits > 0 && bitn == abort_bits) break;
        spi_mosi = fw[w][b];
        wait_ph();
        rd = {rd[6:0], spi_miso_o};
        spi_clk = 1'b1;
        bitn++;
        if (b == 0 && !dead) begin
          rxq.push_back('{cyc + 1 + N, fw[w]});
          last_rise_t = cyc + 1;
        end
        if (bitn == rst_bit) begin
          rst = 1'b1;
          dead = 1'b1;
          selq.push_back('{cyc + 1, 8'h00});
          @(negedge clk);
          rst = 1'b0;
          check_reset("midreset");
        end
        wait_ph();
        spi_clk = 1'b0;
        if (b == 0 && !dead) rdyq.push_back('{cyc + 1 + N, 8'h00});
      end
      if (abort_bits > 0 && bitn == abort_bits) break;
      if (!dead) begin
        reads.push_back(rd);
        if (mexp.size() == 0) bad("miso_word_missing", w, 0);
        else chk("miso_word", rd, mexp.pop_front());
      end
    end
    wait_ph();
    spi_ssn = 1'b1;
    if (!dead) selq.push_back('{cyc + 1 + N, 8'h00});
    wait_ph();
    wait_ph();
    mexp.delete();
  endtask

  task automatic load_tx(input logic [7:0] a, input logic [7:0] b);
    txq.delete();
    txq.push_back(a);
    txq.push_back(b);
    reload_req++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c0, r0, u0, nw;
    repeat (4) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Single word, constant tx 0xA5
    load_tx(8'hA5, 8'hA5);
    fw[0] = 8'h3C;
    c0 = rx_cnt; r0 = rdy_cnt;
    frame(1, 0, 0);
    chk("t1_rx_pulses", rx_cnt - c0, 1);
    chk("t1_rx_dat", rx_dat, 8'h3C);
    chk("t1_master_read", reads[0], 8'hA5);
    chk("t1_tx_rdy_pulses", rdy_cnt - r0, 2);

    // Two-word frame
    load_tx(8'h5A, 8'hC3);
    fw[0] = 8'h01; fw[1] = 8'hFF;
    c0 = rx_cnt;
    frame(2, 0, 0);
    chk("t2_rx_pulses", rx_cnt - c0, 2);
    chk("t2_rx_dat", rx_dat, 8'hFF);
    chk("t2_read0", reads[0], 8'h5A);
    chk("t2_read1", reads[1], 8'hC3);

    // Underflow
    tx_vld = 1'b0;
    fw[0] = 8'h5E;
    u0 = unf_cnt;
    frame(1, 0, 0);
    chk("t3_unf_pulses", unf_cnt - u0, 2);
    chk("t3_read", reads[0], 8'h00);
    chk("t3_rx_dat", rx_dat, 8'h5E);
    tx_vld = 1'b1;

    // Aborted frame after 5 bits, then a full one
    fw[0] = 8'hE7;
    c0 = rx_cnt;
    frame(1, 5, 0);
    chk("t4_no_rx", rx_cnt - c0, 0);
    fw[0] = 8'h96;
    frame(1, 0, 0);
    chk("t4_rx_dat", rx_dat, 8'h96);

    // Reset mid-frame with ssn held low
    fw[0] = 8'h77;
    c0 = rx_cnt;
    frame(1, 0, 3);
    chk("t5_no_rx", rx_cnt - c0, 0);
    fw[0] = 8'h42;
    frame(1, 0, 0);
    chk("t5_rx_dat", rx_dat, 8'h42);

    // Minimum phase width and latency
    min_ph = 1'b1;
    fw[0] = 8'hC9; fw[1] = 8'h36;
    c0 = rx_cnt;
    frame(2, 0, 0);
    chk("t6_rx_pulses", rx_cnt - c0, 2);
    chk("t6_rx_latency", last_rx_cyc - last_rise_t, N);
    min_ph = 1'b0;

    // Randomized frames
    for (int i = 0; i < 12; i++) begin
      nw = int'($urandom_range(1, 3));
      for (int w = 0; w < 4; w++) fw[w] = 8'($urandom);
      tx_vld = 1'($urandom_range(0, 1));
      min_ph = 1'($urandom_range(0, 1));
      c0 = rx_cnt;
      frame(nw, 0, 0);
      chk("rand_rx_pulses", rx_cnt - c0, nw);
    end

    repeat (10) @(negedge clk);
    chk("rxq_drained", rxq.size(), 0);
    chk("rdyq_drained", rdyq.size(), 0);
    chk("selq_drained", selq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
